// File: rtl/cp0_reg_num.sv
// Registered CP0 (rd, sel) -> compact register-file index decoder.
// MMU-owned addresses are flagged separately and never map to a file entry.
module cp0_reg_num (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] rd,
    input  logic [2:0] sel,
    output logic [5:0] regNum,
    output logic       valid,
    output logic       isMMU
);

    localparam logic [5:0] UNMAPPED = 6'd31;

    logic [5:0] num_d;
    logic       valid_d;
    logic       mmu_d;

    always_comb begin
        num_d   = UNMAPPED;
        valid_d = 1'b0;
        mmu_d   = 1'b0;
        if (rd <= 5'd6 || rd == 5'd10) begin
            // MMU group wins regardless of sel
            mmu_d = 1'b1;
        end else begin
            unique case ({rd, sel})
                {5'd7,  3'd0}: num_d = 6'd0;
                {5'd8,  3'd0}: num_d = 6'd1;
                {5'd9,  3'd0}: num_d = 6'd2;
                {5'd11, 3'd0}: num_d = 6'd3;
                {5'd12, 3'd0}: num_d = 6'd4;
                {5'd12, 3'd1}: num_d = 6'd5;
                {5'd12, 3'd2}: num_d = 6'd6;
                {5'd12, 3'd3}: num_d = 6'd7;
                {5'd13, 3'd0}: num_d = 6'd8;
                {5'd14, 3'd0}: num_d = 6'd9;
                {5'd15, 3'd0}: num_d = 6'd10;
                {5'd15, 3'd1}: num_d = 6'd11;
                {5'd16, 3'd0}: num_d = 6'd12;
                {5'd16, 3'd1}: num_d = 6'd13;
                {5'd16, 3'd2}: num_d = 6'd14;
                {5'd16, 3'd3}: num_d = 6'd15;
                {5'd17, 3'd0}: num_d = 6'd16;
                {5'd18, 3'd0}: num_d = 6'd17;
                {5'd19, 3'd0}: num_d = 6'd18;
                {5'd23, 3'd0}: num_d = 6'd19;
                {5'd24, 3'd0}: num_d = 6'd20;
                {5'd25, 3'd0}: num_d = 6'd21;
                {5'd26, 3'd0}: num_d = 6'd22;
                {5'd27, 3'd0}: num_d = 6'd23;
                {5'd28, 3'd0}: num_d = 6'd24;
                {5'd28, 3'd1}: num_d = 6'd25;
                {5'd29, 3'd0}: num_d = 6'd26;
                {5'd29, 3'd1}: num_d = 6'd27;
                {5'd30, 3'd0}: num_d = 6'd28;
                {5'd31, 3'd0}: num_d = 6'd29;
                {5'd20, 3'd0}: num_d = 6'd30;
                default:       num_d = UNMAPPED;
            endcase
            valid_d = (num_d != UNMAPPED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regNum <= UNMAPPED;
            valid  <= 1'b0;
            isMMU  <= 1'b0;
        end else if (en) begin
            regNum <= num_d;
            valid  <= valid_d;
            isMMU  <= mmu_d;
        end
    end

endmodule

// File: tb/tb_cp0_reg_num.sv
// Scoreboard bench for cp0_reg_num: expected decodes are queued at drive time
// and popped once the registered result is visible.
module tb_cp0_reg_num;

    typedef struct packed {
        logic [5:0] num;
        logic       v;
        logic       m;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [4:0] rd = '0;
    logic [2:0] sel = '0;
    logic [5:0] regNum;
    logic       valid;
    logic       isMMU;

    int   checks = 0;
    int   failures = 0;
    res_t q[$];
    res_t last_exp;
    res_t exp_r;
    res_t got;

    // index -> (rd, sel) table, written straight from the register list
    int map_rd[31]  = '{7, 8, 9, 11, 12, 12, 12, 12, 13, 14, 15, 15, 16, 16, 16, 16,
                        17, 18, 19, 23, 24, 25, 26, 27, 28, 28, 29, 29, 30, 31, 20};
    int map_sel[31] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 0, 1, 2, 3,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};

    cp0_reg_num dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rd(rd), .sel(sel),
        .regNum(regNum), .valid(valid), .isMMU(isMMU)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input int r, input int s);
        res_t x;
        x = '{num: 6'd31, v: 1'b0, m: 1'b0};
        if (r <= 6 || r == 10) begin
            x.m = 1'b1;
        end else begin
            for (int i = 0; i < 31; i++)
                if (map_rd[i] == r && map_sel[i] == s) begin
                    x.num = 6'(i);
                    x.v   = 1'b1;
                end
        end
        return x;
    endfunction

    // Present inputs; queue the expected registered value for the next edge.
    task automatic drive(input logic e, input int r, input int s);
        en  = e;
        rd  = 5'(r);
        sel = 3'(s);
        if (e) last_exp = model(r, s);
        q.push_back(last_exp);
        @(posedge clk);
        #1;
        got = {regNum, valid, isMMU};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1; rd = 5'd12; sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({regNum, valid, isMMU} !== {6'd31, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: got num=%0d v=%b m=%b want num=31 v=0 m=0",
                         i, regNum, valid, isMMU);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '{num: 6'd31, v: 1'b0, m: 1'b0};
        // load a mapped value, then clear it asynchronously
        drive(1'b1, 12, 0);
        exp_r = q.pop_front();
        checks++;
        if (got !== exp_r) begin
            failures++;
            $display("FAIL reset_preload: got %h want %h", got, exp_r);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({regNum, valid, isMMU} !== {6'd31, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async: got num=%0d v=%b m=%b want num=31 v=0 m=0",
                     regNum, valid, isMMU);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '{num: 6'd31, v: 1'b0, m: 1'b0};
    endtask

    task automatic test_sweep();
        int nvalid;
        nvalid = 0;
        for (int r = 0; r < 32; r++)
            for (int s = 0; s < 8; s++) begin
                drive(1'b1, r, s);
                exp_r = q.pop_front();
                checks++;
                if (got !== exp_r) begin
                    failures++;
                    $display("FAIL sweep rd=%0d sel=%0d: got num=%0d v=%b m=%b want num=%0d v=%b m=%b",
                             r, s, got.num, got.v, got.m, exp_r.num, exp_r.v, exp_r.m);
                end
                if (got.v === 1'b1) nvalid++;
            end
        checks++;
        if (nvalid != 31) begin
            failures++;
            $display("FAIL sweep_count: got %0d valid pairs want 31", nvalid);
        end
    endtask

    task automatic test_mmu();
        int rs[3] = '{10, 0, 7};
        int ss[3] = '{5, 0, 0};
        res_t want[3];
        want[0] = '{num: 6'd31, v: 1'b0, m: 1'b1};
        want[1] = '{num: 6'd31, v: 1'b0, m: 1'b1};
        want[2] = '{num: 6'd0,  v: 1'b1, m: 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rs[i], ss[i]);
            exp_r = q.pop_front();
            checks++;
            if (got !== want[i] || got !== exp_r) begin
                failures++;
                $display("FAIL mmu rd=%0d sel=%0d: got %h want %h", rs[i], ss[i], got, want[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 15, 1);
        exp_r = q.pop_front();
        checks++;
        if (got.num !== 6'd11 || got !== exp_r) begin
            failures++;
            $display("FAIL hold_load: got num=%0d want 11", got.num);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 13, 0);
            exp_r = q.pop_front();
            checks++;
            if (got.num !== 6'd11 || got !== exp_r) begin
                failures++;
                $display("FAIL hold_cyc%0d: got num=%0d v=%b want 11 v=1", i, got.num, got.v);
            end
        end
        drive(1'b1, 13, 0);
        exp_r = q.pop_front();
        checks++;
        if (got.num !== 6'd8 || got !== exp_r) begin
            failures++;
            $display("FAIL hold_release: got num=%0d want 8", got.num);
        end
    endtask

    task automatic test_back_to_back();
        int rs[3] = '{9, 14, 12};
        int ss[3] = '{0, 0, 4};
        logic [5:0] wn[3] = '{6'd2, 6'd9, 6'd31};
        logic       wv[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rs[i], ss[i]);
            exp_r = q.pop_front();
            checks++;
            if (got.num !== wn[i] || got.v !== wv[i] || got !== exp_r) begin
                failures++;
                $display("FAIL b2b_%0d: got num=%0d v=%b want num=%0d v=%b",
                         i, got.num, got.v, wn[i], wv[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        last_exp = '{num: 6'd31, v: 1'b0, m: 1'b0};
        test_reset();
        test_sweep();
        test_mmu();
        test_hold();
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_reg_num.md
Name: cp0_reg_num

Overview:
- Registered decoder that converts a MIPS32 CP0 register address (rd, sel) into a compact 6-bit index into the non-MMU CP0 register file (31 entries, indices 0..30).
- Flags whether the address belongs to the MMU register group (rd 0..6, 10), which is owned by the MMU block.
- Flags whether the address maps to an implemented file entry.
- Sits between the instruction decode of MTC0/MFC0 and the CP0 register file.

Parameters:
- none

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  sample enable; outputs update only when high
- rd  input  5  CP0 register number
- sel  input  3  CP0 select field
- regNum  output  6  compact file index, 0..30; 31 when not mapped
- valid  output  1  high when (rd, sel) maps to a file entry
- isMMU  output  1  high when rd is 0..6 or 10 (any sel)

Behaviour:
- Reset: asynchronous assertion of rst_n=0 forces regNum=31, valid=0 and isMMU=0 immediately. Release is taken on the next clk edge.
- Latency: 1 cycle. On a rising clk edge with en=1, the outputs load the decode of the current rd/sel. With en=0, all outputs hold their values.
- Mapping (rd/sel -> regNum):
  - 7/0 -> 0 (HWREna)
  - 8/0 -> 1 (BadVAddr)
  - 9/0 -> 2 (Count)
  - 11/0 -> 3 (Compare)
  - 12/0 -> 4 (Status)
  - 12/1 -> 5 (IntCtl)
  - 12/2 -> 6 (SRSCtl)
  - 12/3 -> 7 (SRSMap)
  - 13/0 -> 8 (Cause)
  - 14/0 -> 9 (EPC)
  - 15/0 -> 10 (PRId)
  - 15/1 -> 11 (EBase)
  - 16/0 -> 12 (Config)
  - 16/1 -> 13 (Config1)
  - 16/2 -> 14 (Config2)
  - 16/3 -> 15 (Config3)
  - 17/0 -> 16 (LLAddr)
  - 18/0 -> 17 (WatchLo)
  - 19/0 -> 18 (WatchHi)
  - 23/0 -> 19 (Debug)
  - 24/0 -> 20 (DEPC)
  - 25/0 -> 21 (PerfCnt)
  - 26/0 -> 22 (ErrCtl)
  - 27/0 -> 23 (CacheErr)
  - 28/0 -> 24 (TagLo)
  - 28/1 -> 25 (DataLo)
  - 29/0 -> 26 (TagHi)
  - 29/1 -> 27 (DataHi)
  - 30/0 -> 28 (ErrorEPC)
  - 31/0 -> 29 (DESAVE)
  - 20/0 -> 30 (XContext)
- Mapped entries: valid=1 and isMMU=0.
- MMU group (rd 0..6 or 10, any sel): isMMU=1, valid=0, regNum=31. MMU decoding takes priority over all other rules.
- Any other combination (rd 21, 22; a sel not listed above; e.g. 12/4, 9/1): valid=0, isMMU=0, regNum=31.
- Codes 0..30 are unique; no two (rd, sel) pairs share an index. Consumers must not use regNum when valid=0.
- The decode is purely a function of the sampled rd/sel; no dependence on prior values.
- Back-to-back requests (en=1 on consecutive cycles) give one result per cycle, each reflecting the inputs at its own sampling edge.

Test Plan:
- Reset: hold rst_n=0 with en=1 and rd=12/sel=0 across several edges -> regNum=31, valid=0, isMMU=0. Asserting rst_n mid-stream clears the outputs without waiting for a clock edge.
- Full sweep: en=1, drive all 256 rd/sel combinations, checking each result one cycle later -> exactly the 31 listed pairs give valid=1 with the listed index. For example:
  - 12/0 -> 4
  - 16/3 -> 15
  - 31/0 -> 29
  - 20/0 -> 30
  - All other pairs give regNum=31, valid=0.
- MMU group: rd=10/sel=5 and rd=0/sel=0 -> isMMU=1, valid=0, regNum=31. rd=7/sel=0 -> isMMU=0.
- Hold: load 15/1 (regNum=11), then en=0 while rd/sel change to 13/0 for 3 cycles -> regNum stays 11. Raising en gives 8 on the following edge.
- Pipelining: consecutive-cycle inputs 9/0, 14/0, 12/4 -> outputs 2, 9, then 31 with valid=0, one cycle apart.
